serial_word_collector: RTL and testbench

//  Assembles WIDTH-bit words from a 1-bit serial stream and holds each completed word in a
//  one-entry output register. The held word is presented to the ones-counter stage
//  (7-bit in -> 3-bit count) through a valid/ready handshake.

---
 rtl/serial_word_collector.sv | 114 +++++++++++
 tb/tb_serial_word_collector.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word assembler with a one-entry valid/ready output slot.
// A second completed word is parked in the shift register (FULL) until the slot frees up.
module serial_word_collector #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic             ser_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] words_done
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] complete;
    logic             slot_free;
    logic             xfer;
    logic             last_bit;
    logic             load_new;
    logic             load_sh;

    assign slot_free = !word_valid || word_ready;
    assign xfer      = word_valid && word_ready;
    assign complete  = {sh[WIDTH-2:0], ser_in};
    assign last_bit  = (bit_cnt == BW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // ser_ready depends only on state (and reset), never on word_ready.
    always_comb begin
        state_next = state;
        ser_ready  = 1'b0;
        load_new   = 1'b0;
        load_sh    = 1'b0;
        case (state)
            COLLECT: begin
                ser_ready = !rst;
                if (ser_valid && !flush && last_bit) begin
                    if (slot_free) begin
                        load_new = 1'b1;
                    end else begin
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (slot_free) begin
                    load_sh    = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh         <= '0;
            bit_cnt    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            words_done <= '0;
        end else begin
            if (state == COLLECT) begin
                if (flush) begin
                    sh      <= '0;
                    bit_cnt <= '0;
                end else if (ser_valid) begin
                    sh      <= complete;
                    bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                end
            end

            if (load_new) begin
                word_out <= complete;
            end else if (load_sh) begin
                word_out <= sh;
            end

            // A reload in the same cycle as a transfer keeps the slot occupied.
            if (load_new || load_sh) begin
                word_valid <= 1'b1;
            end else if (xfer) begin
                word_valid <= 1'b0;
            end

            if (xfer) begin
                words_done <= words_done + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector: vector table, directed corner cases,
// and randomized traffic compared against a queue-based word model.
module tb_serial_word_collector;

    localparam int WIDTH = 7;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ser_in;
    logic             ser_valid;
    logic             ser_ready;
    logic             flush;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CNT_W-1:0] words_done;

    int checks = 0;
    int errors = 0;

    serial_word_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .flush     (flush),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .words_done(words_done)
    );

    always #5 clk = ~clk;

    // Reference model: bits of the word being gathered, and completed words not yet taken.
    int               part_q[$];
    logic [WIDTH-1:0] pend_q[$];
    logic [WIDTH-1:0] last_out;
    int               done_total;

    typedef struct {
        logic             rst;
        logic             ser_in;
        logic             ser_valid;
        logic             flush;
        logic             word_ready;
        logic             exp_ready;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_out;
        logic [CNT_W-1:0] exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic r, b, v, f, wr, er, ev,
                                   input logic [WIDTH-1:0] eo, input logic [CNT_W-1:0] ed);
        vec_t t;
        t.rst = r; t.ser_in = b; t.ser_valid = v; t.flush = f; t.word_ready = wr;
        t.exp_ready = er; t.exp_valid = ev; t.exp_out = eo; t.exp_done = ed;
        vecs.push_back(t);
    endfunction

    function automatic void modelStep(input logic r, b, v, f, wr);
        logic             room;
        logic             take;
        logic [WIDTH-1:0] w;
        if (r) begin
            part_q.delete();
            pend_q.delete();
            last_out   = '0;
            done_total = 0;
            return;
        end
        room = (pend_q.size() < 2);
        take = (pend_q.size() > 0) && wr;
        if (room) begin
            if (f) begin
                part_q.delete();
            end else if (v) begin
                part_q.push_back(int'(b));
                if (part_q.size() == WIDTH) begin
                    w = '0;
                    foreach (part_q[i]) w = (w << 1) | WIDTH'(part_q[i]);
                    pend_q.push_back(w);
                    part_q.delete();
                end
            end
        end
        if (take) begin
            void'(pend_q.pop_front());
            done_total++;
        end
        if (pend_q.size() > 0) last_out = pend_q[0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, b, v, f, wr);
        rst = r; ser_in = b; ser_valid = v; flush = f; word_ready = wr;
        modelStep(r, b, v, f, wr);
        @(posedge clk);
        #1;
    endtask

    task automatic compareModel(input string tag);
        checkOutput({tag, "_ser_ready"}, 32'(ser_ready), 32'(!rst && pend_q.size() < 2));
        checkOutput({tag, "_word_valid"}, 32'(word_valid), 32'(pend_q.size() > 0));
        checkOutput({tag, "_word_out"}, 32'(word_out), 32'(last_out));
        checkOutput({tag, "_words_done"}, 32'(words_done), 32'(done_total % (1 << CNT_W)));
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] w, input logic wr, input string tag);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            applyStimulus(1'b0, w[i], 1'b1, 1'b0, wr);
            compareModel(tag);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        int               cyc;

        $display("[TB] start");
        rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;

        // Vector table: reset mid-word, first word, then backpressure with a parked word.
        pat = 7'b1010011;
        addVec(1, 0, 0, 0, 0, 0, 0, 7'h00, 8'd0);
        addVec(0, 1, 1, 0, 0, 1, 0, 7'h00, 8'd0);
        addVec(0, 0, 1, 0, 0, 1, 0, 7'h00, 8'd0);
        addVec(0, 1, 1, 0, 0, 1, 0, 7'h00, 8'd0);
        addVec(1, 1, 1, 0, 0, 0, 0, 7'h00, 8'd0);
        addVec(1, 1, 1, 0, 0, 0, 0, 7'h00, 8'd0);
        for (int i = 0; i < WIDTH; i++)
            addVec(0, pat[WIDTH-1-i], 1, 0, 0, 1, (i == WIDTH - 1), (i == WIDTH - 1) ? 7'h53 : 7'h00, 8'd0);
        addVec(0, 0, 0, 0, 1, 1, 0, 7'h53, 8'd1);
        for (int i = 0; i < WIDTH; i++)
            addVec(0, 1, 1, 0, 0, 1, (i == WIDTH - 1), (i == WIDTH - 1) ? 7'h7F : 7'h53, 8'd1);
        for (int i = 0; i < WIDTH; i++)
            addVec(0, 0, 1, 0, 0, (i != WIDTH - 1), 1, 7'h7F, 8'd1);
        addVec(0, 0, 0, 0, 1, 1, 1, 7'h00, 8'd2);
        addVec(0, 0, 0, 0, 1, 1, 0, 7'h00, 8'd3);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].ser_in, vecs[k].ser_valid, vecs[k].flush, vecs[k].word_ready);
            checkOutput($sformatf("vec%0d_ser_ready", k), 32'(ser_ready), 32'(vecs[k].exp_ready));
            checkOutput($sformatf("vec%0d_word_valid", k), 32'(word_valid), 32'(vecs[k].exp_valid));
            checkOutput($sformatf("vec%0d_word_out", k), 32'(word_out), 32'(vecs[k].exp_out));
            checkOutput($sformatf("vec%0d_words_done", k), 32'(words_done), 32'(vecs[k].exp_done));
        end

        // Exhaustive: every value back-to-back with downstream always ready.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        compareModel("exh_rst");
        for (int v = 0; v < (1 << WIDTH); v++) begin
            sendWord(WIDTH'(v), 1'b1, "exh");
            checkOutput("exh_word", 32'(word_out), 32'(v));
            checkOutput("exh_valid", 32'(word_valid), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("exh_done128", 32'(words_done), 32'd128);

        // Last bit of B accepted in the same cycle A transfers.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendWord(7'h2A, 1'b0, "sim_a");
        pat = 7'h55;
        for (int i = WIDTH - 1; i >= 1; i--) begin
            applyStimulus(1'b0, pat[i], 1'b1, 1'b0, 1'b0);
            compareModel("sim_b");
        end
        applyStimulus(1'b0, pat[0], 1'b1, 1'b0, 1'b1);
        checkOutput("sim_valid", 32'(word_valid), 32'd1);
        checkOutput("sim_word", 32'(word_out), 32'h55);
        checkOutput("sim_done", 32'(words_done), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        compareModel("sim_end");

        // Flush mid-word drops the concurrent bit; flush in FULL keeps the parked word.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            compareModel("fl_pre");
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        compareModel("fl_cyc");
        sendWord(7'b0000011, 1'b1, "fl_word");
        checkOutput("fl_word03", 32'(word_out), 32'h03);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sendWord(7'h11, 1'b0, "fl_c");
        sendWord(7'h66, 1'b0, "fl_d");
        checkOutput("fl_full_ready", 32'(ser_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        compareModel("fl_full");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("fl_kept_word", 32'(word_out), 32'h66);
        checkOutput("fl_kept_valid", 32'(word_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        compareModel("fl_drain");

        // Random gaps, backpressure and occasional flush until 260 transfers.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc = 0;
        while (done_total < 260 && cyc < 20000) begin
            applyStimulus(1'b0, 1'($urandom), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
            compareModel("rnd");
            cyc++;
        end
        checkOutput("rnd_reached_260", 32'(done_total >= 260), 32'd1);
        checkOutput("rnd_done_wrap", 32'(words_done), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
